// File: rtl/display_pkg.sv
// Shared display-mode encodings and push-button bit positions for the
// button front end and the downstream display selector.
package display_pkg;

    localparam logic [1:0] DISP_ORDINARY = 2'b00;
    localparam logic [1:0] DISP_MEMORY   = 2'b01;
    localparam logic [1:0] DISP_PC       = 2'b10;
    localparam logic [1:0] DISP_STATS    = 2'b11;

    localparam int BTN_C = 4;
    localparam int BTN_U = 3;
    localparam int BTN_D = 2;
    localparam int BTN_L = 1;
    localparam int BTN_R = 0;

    typedef enum logic [1:0] {
        MODE_ORDINARY = DISP_ORDINARY,
        MODE_MEMORY   = DISP_MEMORY,
        MODE_PC       = DISP_PC,
        MODE_STATS    = DISP_STATS
    } disp_mode_e;

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-FF synchroniser followed by a stability counter
// that only flips the accepted level after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // Counter clears on acceptance, so it never passes CNT_LAST.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/button_mode_ctrl.sv
// Push-button front end: per-button debounce, rising-edge press strobes,
// sticky display-mode register and the CPU reset level derived from BTNC.
//
// state          | meaning
// MODE_ORDINARY  | ordinary display (C or U pressed, or after reset)
// MODE_MEMORY    | memory view (D pressed)
// MODE_PC        | PC view (L pressed)
// MODE_STATS     | statistics view (R pressed)
module button_mode_ctrl
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [1:0] mode,
    output logic       mode_changed,
    output logic       cpu_reset
);

    logic [4:0] w_level;
    logic [4:0] r_hist;
    logic [4:0] r_press;
    disp_mode_e r_mode;
    disp_mode_e w_mode_next;
    logic       r_mode_changed;
    logic       w_mode_changed_next;

    for (genvar gi = 0; gi < 5; gi++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .i_clk   (clk),
            .i_reset (reset),
            .i_btn   (btn_raw[gi]),
            .o_level (w_level[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist         <= '0;
            r_press        <= '0;
            r_mode         <= MODE_ORDINARY;
            r_mode_changed <= 1'b0;
        end else begin
            r_hist         <= w_level;
            r_press        <= w_level & ~r_hist;
            r_mode         <= w_mode_next;
            r_mode_changed <= w_mode_changed_next;
        end
    end

    // Only the highest-priority coincident strobe is applied: C > U > D > L > R.
    always_comb begin
        w_mode_next         = r_mode;
        w_mode_changed_next = 1'b0;
        if (r_press[BTN_C] || r_press[BTN_U]) begin
            w_mode_next = MODE_ORDINARY;
        end else if (r_press[BTN_D]) begin
            w_mode_next = MODE_MEMORY;
        end else if (r_press[BTN_L]) begin
            w_mode_next = MODE_PC;
        end else if (r_press[BTN_R]) begin
            w_mode_next = MODE_STATS;
        end
        w_mode_changed_next = (w_mode_next != r_mode);
    end

    assign btn_level    = w_level;
    assign btn_press    = r_press;
    assign mode         = r_mode;
    assign mode_changed = r_mode_changed;
    assign cpu_reset    = w_level[BTN_C];

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Directed bench for button_mode_ctrl with a 4-cycle debounce window.
// Timing reference: raw edge applied before clock edge 1 -> level after edge 6, press after edge 7, mode after edge 8.
module tb_button_mode_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [1:0] mode;
    logic       mode_changed;
    logic       cpu_reset;

    int n_checks = 0;
    int n_fail   = 0;

    button_mode_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .mode         (mode),
        .mode_changed (mode_changed),
        .cpu_reset    (cpu_reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        logic [10:0] seen;
        reset   = 1'b1;
        btn_raw = 5'b0;
        tick(3);
        n_checks++;
        if ({btn_level, btn_press, mode, mode_changed, cpu_reset} !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected all zero",
                     {btn_level, btn_press, mode, mode_changed, cpu_reset});
        end
        reset = 1'b0;
        seen  = '0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            seen |= {btn_level, btn_press, mode_changed};
        end
        n_checks++;
        if (seen !== 11'b0 || mode !== 2'b00 || cpu_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_outputs: got seen=%b mode=%b cpu_reset=%b expected 0/00/0",
                     seen, mode, cpu_reset);
        end
    endtask

    task automatic test_clean_press_d;
        logic [4:0] press_seen;
        btn_raw[2] = 1'b1;
        tick(5);
        n_checks++;
        if (btn_level !== 5'b00000) begin
            n_fail++;
            $display("FAIL d_level_early: got %b expected 00000", btn_level);
        end
        tick(1);
        n_checks++;
        if (btn_level !== 5'b00100 || btn_press !== 5'b00000) begin
            n_fail++;
            $display("FAIL d_level_rise: got level=%b press=%b expected 00100/00000", btn_level, btn_press);
        end
        tick(1);
        n_checks++;
        if (btn_press !== 5'b00100 || mode !== 2'b00 || mode_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL d_press: got press=%b mode=%b chg=%b expected 00100/00/0",
                     btn_press, mode, mode_changed);
        end
        tick(1);
        n_checks++;
        if (btn_press !== 5'b00000 || mode !== 2'b01 || mode_changed !== 1'b1) begin
            n_fail++;
            $display("FAIL d_mode_update: got press=%b mode=%b chg=%b expected 00000/01/1",
                     btn_press, mode, mode_changed);
        end
        tick(1);
        n_checks++;
        if (mode_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL d_changed_one_cycle: got %b expected 0", mode_changed);
        end
        btn_raw[2] = 1'b0;
        press_seen = '0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            press_seen |= btn_press;
        end
        n_checks++;
        if (mode !== 2'b01 || btn_level !== 5'b0 || press_seen !== 5'b0) begin
            n_fail++;
            $display("FAIL d_release_sticky: got mode=%b level=%b press=%b expected 01/00000/00000",
                     mode, btn_level, press_seen);
        end
    endtask

    task automatic test_bounce_rejection;
        logic [4:0] bounce_seen;
        int         n_press;
        bounce_seen = '0;
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = (i % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                tick(1);
                bounce_seen |= btn_level | btn_press;
            end
        end
        n_checks++;
        if (bounce_seen !== 5'b0) begin
            n_fail++;
            $display("FAIL bounce_no_press: got %b expected 00000", bounce_seen);
        end
        btn_raw[0] = 1'b1;
        n_press = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (btn_press[0]) n_press++;
        end
        n_checks++;
        if (n_press != 1 || mode !== 2'b11) begin
            n_fail++;
            $display("FAIL bounce_settle: got presses=%0d mode=%b expected 1/11", n_press, mode);
        end
        btn_raw[0] = 1'b0;
        tick(10);
    endtask

    task automatic test_simultaneous;
        btn_raw[1:0] = 2'b11;
        tick(7);
        n_checks++;
        if (btn_press !== 5'b00011) begin
            n_fail++;
            $display("FAIL simul_press: got %b expected 00011", btn_press);
        end
        tick(1);
        n_checks++;
        if (mode !== 2'b10 || mode_changed !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_mode: got mode=%b chg=%b expected 10/1", mode, mode_changed);
        end
        btn_raw[1:0] = 2'b00;
        tick(10);
    endtask

    task automatic test_redundant;
        btn_raw[1] = 1'b1;
        tick(7);
        n_checks++;
        if (btn_press !== 5'b00010) begin
            n_fail++;
            $display("FAIL redundant_press: got %b expected 00010", btn_press);
        end
        tick(1);
        n_checks++;
        if (mode !== 2'b10 || mode_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL redundant_no_change: got mode=%b chg=%b expected 10/0", mode, mode_changed);
        end
        btn_raw[1] = 1'b0;
        tick(10);
    endtask

    task automatic test_btnc;
        btn_raw[4] = 1'b1;
        tick(5);
        n_checks++;
        if (cpu_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL c_cpu_reset_early: got %b expected 0", cpu_reset);
        end
        tick(1);
        n_checks++;
        if (cpu_reset !== 1'b1 || btn_level !== 5'b10000) begin
            n_fail++;
            $display("FAIL c_cpu_reset_rise: got cpu_reset=%b level=%b expected 1/10000", cpu_reset, btn_level);
        end
        tick(2);
        n_checks++;
        if (mode !== 2'b00 || mode_changed !== 1'b1) begin
            n_fail++;
            $display("FAIL c_mode: got mode=%b chg=%b expected 00/1", mode, mode_changed);
        end
        tick(5);
        n_checks++;
        if (cpu_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL c_held: got %b expected 1", cpu_reset);
        end
        btn_raw[4] = 1'b0;
        tick(5);
        n_checks++;
        if (cpu_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL c_release_early: got %b expected 1", cpu_reset);
        end
        tick(1);
        n_checks++;
        if (cpu_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL c_release_fall: got %b expected 0", cpu_reset);
        end
        tick(4);
    endtask

    task automatic test_reset_mid_debounce;
        logic [4:0] seen;
        btn_raw[3] = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(2);
        n_checks++;
        if ({btn_level, btn_press, mode, mode_changed} !== 13'b0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got %b expected all zero",
                     {btn_level, btn_press, mode, mode_changed});
        end
        reset = 1'b0;
        seen  = '0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            seen |= btn_level | btn_press;
        end
        n_checks++;
        if (seen !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_requalify_early: got %b expected 00000", seen);
        end
        tick(1);
        n_checks++;
        if (btn_level !== 5'b01000 || btn_press !== 5'b00000) begin
            n_fail++;
            $display("FAIL mid_level: got level=%b press=%b expected 01000/00000", btn_level, btn_press);
        end
        tick(1);
        n_checks++;
        if (btn_press !== 5'b01000) begin
            n_fail++;
            $display("FAIL mid_press: got %b expected 01000", btn_press);
        end
        tick(1);
        n_checks++;
        if (btn_press !== 5'b00000 || mode !== 2'b00 || mode_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: got press=%b mode=%b chg=%b expected 00000/00/0",
                     btn_press, mode, mode_changed);
        end
        btn_raw[3] = 1'b0;
        tick(10);
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 5'b0;
        test_reset();
        test_clean_press_d();
        test_bounce_rejection();
        test_simultaneous();
        test_redundant();
        test_btnc();
        test_reset_mid_debounce();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
